// File: rtl/fpu_read_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// fpu_read_fill_ctrl_if
//
// Purpose:
//   Bundles the job control, memory beat handshake, request buffer write port
//   and consumer bank handshake of the FPU read-bank fill controller. The fill
//   controller connects through the master modport. The surrounding system
//   (memory, request buffer, column-read consumer) connects through the slave
//   modport.
//
// Signals (direction as seen by the fill controller):
//   start                 in   one-cycle job start pulse
//   num_banks             in   bank fills in the job, sampled on start
//   mem_data_valid        in   memory beat valid
//   mem_data              in   64-bit memory beat, byte 0 at [7:0]
//   mem_data_ready        out  beat accepted when valid && ready
//   request_write_address out  {column, row} write address
//   request_data_in       out  registered beat data
//   wr_en_rd_buffer       out  buffer write strobe
//   rd_buffer_sel         out  0: fill bank1 / consumer bank0, 1: reverse
//   bank_valid            out  consumer-side bank holds an unconsumed fill
//   consume_done          in   consumer releases its bank (pulse)
//   busy                  out  job in progress
//   done                  out  job complete (pulse)
// -----------------------------------------------------------------------------
interface fpu_read_fill_ctrl_if #(
  parameter int BUFFER_DEPTH = 512,
  parameter int COL_WIDTH    = 10
);

  localparam int BADDR_BITS = $clog2(BUFFER_DEPTH);
  localparam int CADDR_BITS = $clog2(COL_WIDTH);

  logic                             start;
  logic [15:0]                      num_banks;
  logic                             mem_data_valid;
  logic [63:0]                      mem_data;
  logic                             mem_data_ready;
  logic [BADDR_BITS+CADDR_BITS-1:0] request_write_address;
  logic [63:0]                      request_data_in;
  logic                             wr_en_rd_buffer;
  logic                             rd_buffer_sel;
  logic                             bank_valid;
  logic                             consume_done;
  logic                             busy;
  logic                             done;

  // Fill controller side
  modport master (
    input  start,
    input  num_banks,
    input  mem_data_valid,
    input  mem_data,
    input  consume_done,
    output mem_data_ready,
    output request_write_address,
    output request_data_in,
    output wr_en_rd_buffer,
    output rd_buffer_sel,
    output bank_valid,
    output busy,
    output done
  );

  // System side: memory source, request buffer and column-read consumer
  modport slave (
    output start,
    output num_banks,
    output mem_data_valid,
    output mem_data,
    output consume_done,
    input  mem_data_ready,
    input  request_write_address,
    input  request_data_in,
    input  wr_en_rd_buffer,
    input  rd_buffer_sel,
    input  bank_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/fpu_read_fill_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_read_fill_ctrl
//
// Purpose:
//   Upstream fill stage for the FPU request buffer's ping-pong read banks.
//   64-bit memory beats are accepted over a valid/ready handshake. Each beat is
//   written column-major into the bank being filled: eight bytes per beat, the
//   row steps by 8 down a column, and then the next column starts. When a bank
//   is full the controller waits until the consumer has released the other
//   bank. It then flips rd_buffer_sel, which hands the fresh bank to the
//   consumer, and starts the next fill.
//
// Parameters:
//   BUFFER_DEPTH  rows (bytes) per bank column, multiple of 8
//   COL_WIDTH     columns per bank
//
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    fpu_read_fill_ctrl_if.master (see interface file for signal list)
// -----------------------------------------------------------------------------
module fpu_read_fill_ctrl #(
  parameter int BUFFER_DEPTH = 512,
  parameter int COL_WIDTH    = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fpu_read_fill_ctrl_if.master        bus
);

  localparam int BADDR_BITS    = $clog2(BUFFER_DEPTH);
  localparam int CADDR_BITS    = $clog2(COL_WIDTH);
  localparam int BEATS_PER_COL = BUFFER_DEPTH / 8;
  // The beat counter needs at least one bit even for a single-beat column
  localparam int BEAT_BITS     = (BADDR_BITS > 3) ? (BADDR_BITS - 3) : 1;

  localparam logic [BEAT_BITS-1:0]  LAST_BEAT = BEAT_BITS'(BEATS_PER_COL - 1);
  localparam logic [CADDR_BITS-1:0] LAST_COL  = CADDR_BITS'(COL_WIDTH - 1);

  // Rows are addressed in bytes, so partial beats would break the addressing
  if (BUFFER_DEPTH % 8 != 0) begin : g_badDepth
    $error("fpu_read_fill_ctrl: BUFFER_DEPTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SWAP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_nextState;

  logic [BEAT_BITS-1:0]             r_beat;
  logic [CADDR_BITS-1:0]            r_col;
  logic [15:0]                      r_filledCnt;
  logic [15:0]                      r_numBanks;

  logic                             r_wrEn;
  logic [BADDR_BITS+CADDR_BITS-1:0] r_addr;
  logic [63:0]                      r_data;
  logic                             r_sel;
  logic                             r_bankValid;
  logic                             r_done;

  logic                             w_memDataReady;
  logic                             w_busy;
  logic                             w_handshake;
  logic                             w_lastBeat;
  logic                             w_swapGo;
  logic                             w_startAccept;
  logic                             w_startEmpty;
  logic                             w_drainDone;
  logic [BADDR_BITS-1:0]            w_row;

  // The handshake and the job-level events that the FSM and datapath share
  assign w_handshake   = w_memDataReady && bus.mem_data_valid;
  assign w_lastBeat    = w_handshake && (r_beat == LAST_BEAT) && (r_col == LAST_COL);
  // Swap once the consumer bank is free. A release arriving in this same cycle also frees it
  assign w_swapGo      = (r_state == SWAP) && (!r_bankValid || bus.consume_done);
  assign w_startAccept = (r_state == IDLE) && bus.start && (bus.num_banks != 16'd0);
  assign w_startEmpty  = (r_state == IDLE) && bus.start && (bus.num_banks == 16'd0);
  assign w_drainDone   = (r_state == DRAIN) && !r_bankValid;

  // Byte row of the current beat: beat index times 8
  assign w_row = BADDR_BITS'({r_beat, 3'b000});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_startAccept) begin
          w_nextState = FILL;
        end
      end
      FILL: begin
        if (w_lastBeat) begin
          w_nextState = SWAP;
        end
      end
      SWAP: begin
        if (w_swapGo) begin
          w_nextState = (r_filledCnt == r_numBanks) ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (w_drainDone) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    w_memDataReady = 1'b0;
    w_busy         = 1'b0;
    unique case (r_state)
      IDLE:    w_busy = 1'b0;
      FILL: begin
        w_memDataReady = 1'b1;
        w_busy         = 1'b1;
      end
      SWAP:    w_busy = 1'b1;
      DRAIN:   w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Write port register. The data, address and strobe of a beat appear one
  // cycle after its handshake. The address is taken from the counters before
  // they advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrEn <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wrEn <= w_handshake;
      if (w_handshake) begin
        r_addr <= {r_col, w_row};
        r_data <= bus.mem_data;
      end
    end
  end

  // Beat/column position within the bank being filled. It starts from zero
  // on every job and after every swap. It wraps to zero on the final beat
  // so the counters never go outside the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_col  <= '0;
    end else if (w_startAccept || w_swapGo) begin
      r_beat <= '0;
      r_col  <= '0;
    end else if (w_handshake) begin
      if (r_beat == LAST_BEAT) begin
        r_beat <= '0;
        r_col  <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Job length bookkeeping. num_banks is sampled only when a start is
  // accepted, so a start arriving during a job cannot change the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filledCnt <= '0;
      r_numBanks  <= '0;
    end else if (w_startAccept) begin
      r_filledCnt <= '0;
      r_numBanks  <= bus.num_banks;
    end else if (w_lastBeat) begin
      r_filledCnt <= r_filledCnt + 16'd1;
    end
  end

  // Bank ownership. rd_buffer_sel only flips in SWAP, after the last write
  // of the bank has already gone out with the old select. If a swap hands
  // over a new bank in the same cycle that the consumer releases its old
  // one, the new bank stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 1'b0;
      r_bankValid <= 1'b0;
    end else begin
      if (w_swapGo) begin
        r_sel       <= ~r_sel;
        r_bankValid <= 1'b1;
      end else if (bus.consume_done) begin
        r_bankValid <= 1'b0;
      end
    end
  end

  // done is registered so that it lines up with busy already low: the FSM
  // is back in IDLE in the cycle the pulse is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_startEmpty || w_drainDone;
    end
  end

  assign bus.mem_data_ready        = w_memDataReady;
  assign bus.busy                  = w_busy;
  assign bus.wr_en_rd_buffer       = r_wrEn;
  assign bus.request_write_address = r_addr;
  assign bus.request_data_in       = r_data;
  assign bus.rd_buffer_sel         = r_sel;
  assign bus.bank_valid            = r_bankValid;
  assign bus.done                  = r_done;

endmodule

// File: tb/tb_fpu_read_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_read_fill_ctrl
//
// Directed bench for the read-bank fill controller using a small geometry
// (16-byte columns, 3 columns). That gives 6 beats per bank, at addresses
// {col,row} = 0x00,0x08,0x10,0x18,0x20,0x28.
// -----------------------------------------------------------------------------
module tb_fpu_read_fill_ctrl;

  localparam int BUFFER_DEPTH = 16;
  localparam int COL_WIDTH    = 3;

  localparam logic [63:0] BASE1 = 64'hA100_0000_0000_0000;
  localparam logic [63:0] BASE2 = 64'hB200_0000_0000_0000;
  localparam logic [63:0] BASE3 = 64'hC300_0000_0000_0000;
  localparam logic [63:0] BASE4 = 64'hD400_0000_0000_0000;
  localparam logic [63:0] BASE5 = 64'hE500_0000_0000_0000;
  localparam logic [63:0] BASE6 = 64'hF600_0000_0000_0000;
  localparam logic [63:0] BASE7 = 64'h1700_0000_0000_0000;
  localparam logic [63:0] BASE8 = 64'h2800_0000_0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   nCompared   = 0;
  int   nMismatched = 0;
  int   hsCount     = 0;
  int   latErr      = 0;
  int   hs0         = 0;
  logic hsPrev      = 1'b0;

  logic [5:0]  wrAddr[$];
  logic [63:0] wrData[$];
  logic        wrSel[$];
  logic [5:0]  expAddr [6];

  always #5 clk = ~clk;

  fpu_read_fill_ctrl_if #(.BUFFER_DEPTH(BUFFER_DEPTH), .COL_WIDTH(COL_WIDTH)) bus ();

  fpu_read_fill_ctrl #(.BUFFER_DEPTH(BUFFER_DEPTH), .COL_WIDTH(COL_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Write/handshake monitor, sampled on the inactive edge. Every write must
  // follow a handshake in the previous cycle, and every handshake must be
  // followed by a write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en_rd_buffer !== hsPrev) latErr++;
      if (bus.wr_en_rd_buffer === 1'b1) begin
        wrAddr.push_back(bus.request_write_address);
        wrData.push_back(bus.request_data_in);
        wrSel.push_back(bus.rd_buffer_sel);
      end
      if (bus.mem_data_valid && bus.mem_data_ready) hsCount++;
      hsPrev = bus.mem_data_valid && bus.mem_data_ready;
    end else begin
      hsPrev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of control inputs; start and consume_done are pulses
  task automatic applyStimulus(input logic st, input logic [15:0] nb, input logic cd);
    bus.start        = st;
    bus.num_banks    = nb;
    bus.consume_done = cd;
    tick();
    bus.start        = 1'b0;
    bus.consume_done = 1'b0;
  endtask

  // Memory source: offer beats base+0, base+1, ... until n are accepted
  task automatic feedBeats(input int n, input bit toggle, input logic [63:0] base);
    int   k   = 0;
    int   cyc = 0;
    logic hsNow;
    while (k < n && cyc < 64) begin
      bus.mem_data_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.mem_data       = base + 64'(k);
      hsNow              = bus.mem_data_valid && bus.mem_data_ready;
      tick();
      if (hsNow) k++;
      cyc++;
    end
    bus.mem_data_valid = 1'b0;
    checkOutput("feed_count", 64'(k), 64'(n));
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrSel.delete();
  endtask

  task automatic checkFillLog(input string tag, input logic [63:0] base, input logic expSel);
    checkOutput({tag, "_wr_count"}, 64'(wrAddr.size()), 64'd6);
    for (int i = 0; i < 6 && i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(wrAddr[i]), 64'(expAddr[i]));
      checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], base + 64'(i));
      checkOutput($sformatf("%s_sel%0d", tag, i), 64'(wrSel[i]), 64'(expSel));
    end
    clearLog();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 64'(bus.mem_data_ready), 64'd0);
    checkOutput({tag, "_wr_en"}, 64'(bus.wr_en_rd_buffer), 64'd0);
    checkOutput({tag, "_addr"}, 64'(bus.request_write_address), 64'd0);
    checkOutput({tag, "_data"}, bus.request_data_in, 64'd0);
    checkOutput({tag, "_sel"}, 64'(bus.rd_buffer_sel), 64'd0);
    checkOutput({tag, "_bank_valid"}, 64'(bus.bank_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    expAddr = '{6'h00, 6'h08, 6'h10, 6'h18, 6'h20, 6'h28};
    bus.start          = 1'b0;
    bus.num_banks      = 16'd0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 64'd0;
    bus.consume_done   = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    checkAllZero("rst");
    rst_n = 1'b1;
    tick();

    // 1: single bank, valid held high
    applyStimulus(1'b1, 16'd1, 1'b0);
    checkOutput("t1_busy", 64'(bus.busy), 64'd1);
    checkOutput("t1_ready", 64'(bus.mem_data_ready), 64'd1);
    feedBeats(6, 1'b0, BASE1);
    checkOutput("t1_last_wr", 64'(bus.wr_en_rd_buffer), 64'd1);
    checkOutput("t1_last_addr", 64'(bus.request_write_address), 64'h28);
    checkOutput("t1_swap_ready", 64'(bus.mem_data_ready), 64'd0);
    checkOutput("t1_sel_old", 64'(bus.rd_buffer_sel), 64'd0);
    checkOutput("t1_bv_old", 64'(bus.bank_valid), 64'd0);
    tick();
    checkOutput("t1_sel_new", 64'(bus.rd_buffer_sel), 64'd1);
    checkOutput("t1_bv_new", 64'(bus.bank_valid), 64'd1);
    checkOutput("t1_wr_idle", 64'(bus.wr_en_rd_buffer), 64'd0);
    checkOutput("t1_drain_busy", 64'(bus.busy), 64'd1);
    checkFillLog("t1", BASE1, 1'b0);
    applyStimulus(1'b0, 16'd1, 1'b1);
    checkOutput("t1_bv_released", 64'(bus.bank_valid), 64'd0);
    checkOutput("t1_done_early", 64'(bus.done), 64'd0);
    tick();
    checkOutput("t1_done", 64'(bus.done), 64'd1);
    checkOutput("t1_done_busy", 64'(bus.busy), 64'd0);
    tick();
    checkOutput("t1_done_pulse", 64'(bus.done), 64'd0);
    checkOutput("t1_latency", 64'(latErr), 64'd0);

    // 2: three banks, consumer withholds release after the second fill
    applyStimulus(1'b1, 16'd3, 1'b0);
    feedBeats(6, 1'b0, BASE2);
    tick();
    checkOutput("t2_sel_a", 64'(bus.rd_buffer_sel), 64'd0);
    checkOutput("t2_bv_a", 64'(bus.bank_valid), 64'd1);
    checkOutput("t2_ready_a", 64'(bus.mem_data_ready), 64'd1);
    checkFillLog("t2a", BASE2, 1'b1);
    feedBeats(6, 1'b0, BASE3);
    tick();
    tick();
    tick();
    checkOutput("t2_stall_ready", 64'(bus.mem_data_ready), 64'd0);
    checkOutput("t2_stall_sel", 64'(bus.rd_buffer_sel), 64'd0);
    checkOutput("t2_stall_bv", 64'(bus.bank_valid), 64'd1);
    checkOutput("t2_stall_wr", 64'(bus.wr_en_rd_buffer), 64'd0);
    checkFillLog("t2b", BASE3, 1'b0);
    applyStimulus(1'b0, 16'd3, 1'b1);
    checkOutput("t2_rel_sel", 64'(bus.rd_buffer_sel), 64'd1);
    checkOutput("t2_rel_bv", 64'(bus.bank_valid), 64'd1);
    checkOutput("t2_rel_ready", 64'(bus.mem_data_ready), 64'd1);

    // 3: third fill, consume_done in the very cycle SWAP is entered
    feedBeats(6, 1'b0, BASE4);
    checkOutput("t3_entry_bv", 64'(bus.bank_valid), 64'd1);
    checkOutput("t3_entry_wr", 64'(bus.wr_en_rd_buffer), 64'd1);
    applyStimulus(1'b0, 16'd3, 1'b1);
    checkOutput("t3_sel", 64'(bus.rd_buffer_sel), 64'd0);
    checkOutput("t3_bv", 64'(bus.bank_valid), 64'd1);
    checkOutput("t3_busy", 64'(bus.busy), 64'd1);
    checkOutput("t3_ready", 64'(bus.mem_data_ready), 64'd0);
    checkFillLog("t3", BASE4, 1'b1);
    applyStimulus(1'b0, 16'd3, 1'b1);
    checkOutput("t3_bv_released", 64'(bus.bank_valid), 64'd0);
    tick();
    checkOutput("t3_done", 64'(bus.done), 64'd1);
    checkOutput("t3_done_busy", 64'(bus.busy), 64'd0);
    tick();
    checkOutput("t3_latency", 64'(latErr), 64'd0);

    // 4: valid toggling 1,0,1,0
    hs0 = hsCount;
    applyStimulus(1'b1, 16'd1, 1'b0);
    feedBeats(6, 1'b1, BASE5);
    tick();
    checkOutput("t4_hs_count", 64'(hsCount - hs0), 64'd6);
    checkOutput("t4_wr_vs_hs", 64'(wrAddr.size()), 64'(hsCount - hs0));
    checkOutput("t4_sel", 64'(bus.rd_buffer_sel), 64'd1);
    checkFillLog("t4", BASE5, 1'b0);
    applyStimulus(1'b0, 16'd1, 1'b1);
    tick();
    checkOutput("t4_done", 64'(bus.done), 64'd1);
    tick();
    checkOutput("t4_latency", 64'(latErr), 64'd0);

    // 5: reset after the fourth beat of a fill
    applyStimulus(1'b1, 16'd1, 1'b0);
    feedBeats(4, 1'b0, BASE6);
    checkOutput("t5_pre_wr", 64'(bus.wr_en_rd_buffer), 64'd1);
    checkOutput("t5_pre_sel", 64'(bus.rd_buffer_sel), 64'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("t5_rst");
    tick();
    rst_n = 1'b1;
    tick();
    clearLog();
    applyStimulus(1'b1, 16'd1, 1'b0);
    feedBeats(6, 1'b0, BASE7);
    tick();
    checkFillLog("t5", BASE7, 1'b0);
    checkOutput("t5_sel_after", 64'(bus.rd_buffer_sel), 64'd1);
    applyStimulus(1'b0, 16'd1, 1'b1);
    tick();
    checkOutput("t5_done", 64'(bus.done), 64'd1);
    tick();

    // 6: empty job, then a start during busy that must not resample num_banks
    applyStimulus(1'b1, 16'd0, 1'b0);
    checkOutput("t6_empty_done", 64'(bus.done), 64'd1);
    checkOutput("t6_empty_busy", 64'(bus.busy), 64'd0);
    checkOutput("t6_empty_sel", 64'(bus.rd_buffer_sel), 64'd1);
    tick();
    checkOutput("t6_empty_pulse", 64'(bus.done), 64'd0);
    checkOutput("t6_empty_writes", 64'(wrAddr.size()), 64'd0);
    bus.start     = 1'b1;
    bus.num_banks = 16'd1;
    tick();
    checkOutput("t6_busy", 64'(bus.busy), 64'd1);
    bus.num_banks = 16'd5;
    feedBeats(6, 1'b0, BASE8);
    bus.start = 1'b0;
    tick();
    checkOutput("t6_drain_ready", 64'(bus.mem_data_ready), 64'd0);
    checkOutput("t6_bv", 64'(bus.bank_valid), 64'd1);
    checkOutput("t6_sel", 64'(bus.rd_buffer_sel), 64'd0);
    checkFillLog("t6", BASE8, 1'b1);
    applyStimulus(1'b0, 16'd5, 1'b1);
    tick();
    checkOutput("t6_done", 64'(bus.done), 64'd1);
    checkOutput("t6_done_busy", 64'(bus.busy), 64'd0);
    tick();
    checkOutput("t6_latency", 64'(latErr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
